vga_stream_out: RTL and testbench

//  Final display stage of the image platform: consumes the role's AXI-Stream pixel stream and drives
//  the board VGA pins (vga_r/g/b 4-bit each, vga_hsync, vga_vsync).

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_raster_cnt.sv | 58 +++++
 rtl/vga_stream_out.sv | 153 +++++++++++++++
 tb/tb_vga_stream_out.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 raster timing for the VGA output stage.
package vga_pkg;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } vga_state_t;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

endpackage

// File: rtl/vga_raster_cnt.sv
// Free-running horizontal/vertical raster counters and their region decode.
module vga_raster_cnt import vga_pkg::*; #(
    parameter int H_ACTIVE = VGA_640X480_H.active,
    parameter int H_FP     = VGA_640X480_H.fp,
    parameter int H_SYNC   = VGA_640X480_H.sync,
    parameter int H_BP     = VGA_640X480_H.bp,
    parameter int V_ACTIVE = VGA_640X480_V.active,
    parameter int V_FP     = VGA_640X480_V.fp,
    parameter int V_SYNC   = VGA_640X480_V.sync,
    parameter int V_BP     = VGA_640X480_V.bp,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hs_act,
    output logic          vs_act,
    output logic          frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic h_end;
    logic v_end;

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Compare in 32-bit so sync windows ending exactly at the total never truncate.
    assign active    = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs_act    = (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END);
    assign vs_act    = (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END);
    assign frame_end = h_end && v_end;

endmodule

// File: rtl/vga_stream_out.sv
// AXI-Stream to VGA output stage: locks stream frames to the raster via SOF/EOL,
// flags underflow and framing errors, and resynchronises at the next frame boundary.
module vga_stream_out import vga_pkg::*; #(
    parameter int H_ACTIVE = VGA_640X480_H.active,
    parameter int H_FP     = VGA_640X480_H.fp,
    parameter int H_SYNC   = VGA_640X480_H.sync,
    parameter int H_BP     = VGA_640X480_H.bp,
    parameter int V_ACTIVE = VGA_640X480_V.active,
    parameter int V_FP     = VGA_640X480_V.fp,
    parameter int V_SYNC   = VGA_640X480_V.sync,
    parameter int V_BP     = VGA_640X480_V.bp,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start,
    output logic        underflow,
    output logic        sync_err,
    input  logic        clr_status
);

    localparam int   HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int   VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active_p0;
    logic          hs_p0;
    logic          vs_p0;
    logic          frame_end_p0;

    vga_raster_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (active_p0),
        .hs_act    (hs_p0),
        .vs_act    (vs_p0),
        .frame_end (frame_end_p0)
    );

    vga_state_t  state;
    logic        resync;
    logic        sof_pos;
    logic        eol_pos;
    logic        vld_p0;
    logic        miss_p0;
    logic        bad_p0;
    logic [11:0] rgb_p1;
    logic        hsync_p1;
    logic        vsync_p1;

    assign sof_pos = (h_cnt == '0) && (v_cnt == '0);
    assign eol_pos = (32'(h_cnt) == H_ACTIVE - 1);

    // In SEEK the SOF beat is refused so it stays pending until the raster reaches (0,0).
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            SEEK:    s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
            RUN:     s_axis_tready = active_p0;
            default: s_axis_tready = 1'b0;
        endcase
    end

    assign vld_p0  = (state == RUN) && active_p0 && s_axis_tvalid;
    assign miss_p0 = (state == RUN) && active_p0 && !s_axis_tvalid;
    assign bad_p0  = vld_p0 && ((s_axis_tuser != sof_pos) || (s_axis_tlast != eol_pos));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEEK;
            resync      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                SEEK: begin
                    if (s_axis_tvalid && s_axis_tuser)
                        state <= WAIT;
                end
                WAIT: begin
                    if (frame_end_p0) begin
                        state       <= RUN;
                        frame_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (miss_p0 || bad_p0)
                        resync <= 1'b1;
                    if (frame_end_p0) begin
                        if (resync) begin
                            resync <= 1'b0;
                            state  <= SEEK;
                        end else begin
                            frame_start <= 1'b1;
                        end
                    end
                end
                default: state <= SEEK;
            endcase
        end
    end

    // p0 -> p1: colour, syncs and sticky flags registered together so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_p1    <= '0;
            hsync_p1  <= ~HS_ON;
            vsync_p1  <= ~VS_ON;
            underflow <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            rgb_p1    <= vld_p0 ? s_axis_tdata : 12'h000;
            hsync_p1  <= hs_p0 ? HS_ON : ~HS_ON;
            vsync_p1  <= vs_p0 ? VS_ON : ~VS_ON;
            underflow <= miss_p0 | (underflow & ~clr_status);
            sync_err  <= bad_p0 | (sync_err & ~clr_status);
        end
    end

    assign vga_r     = rgb_p1[11:8];
    assign vga_g     = rgb_p1[7:4];
    assign vga_b     = rgb_p1[3:0];
    assign vga_hsync = hsync_p1;
    assign vga_vsync = vsync_p1;

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on an 8x4 visible raster (14x7 total, 98 clocks/frame).
module tb_vga_stream_out;

    localparam int HT = 14;
    localparam int FT = 98;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;
    logic        frame_start, underflow, sync_err;
    logic        clr_status = 1'b0;

    vga_stream_out #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (0), .VS_POL (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .sync_err      (sync_err),
        .clr_status    (clr_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;    // 0 none, 1 one-cycle tvalid gap, 2 early tlast, 3 stray tuser
        int ix;
        int iy;
        int s2;      // source frame shown in raster frame 2 (-1 = black)
        int s3;
        int exp_uf;
        int exp_se;
        int exp_b1;  // beats accepted during raster frame 1
        int exp_b2;
    } vec_t;

    vec_t vecs[4];

    int total = 0;
    int bad   = 0;
    int k;
    int src_f, src_x, src_y;
    int inj_kind, inj_x, inj_y;
    int show[5];
    int acc[5];

    function automatic logic [11:0] pix(input int f, input int x, input int y);
        return {4'(f + 1), 4'(y), 4'(x)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, k);
        end
    endtask

    task automatic drive_src();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pix(src_f, src_x, src_y);
        s_axis_tuser  = (src_x == 0) && (src_y == 0);
        s_axis_tlast  = (src_x == 7);
        if (src_f == 0 && src_x == inj_x && src_y == inj_y) begin
            if (inj_kind == 1) s_axis_tvalid = 1'b0;
            if (inj_kind == 2) s_axis_tlast  = 1'b1;
            if (inj_kind == 3) s_axis_tuser  = 1'b1;
        end
    endtask

    task automatic advance();
        src_x++;
        if (src_x == 8) begin
            src_x = 0;
            src_y++;
            if (src_y == 4) begin
                src_y = 0;
                src_f++;
            end
        end
    endtask

    task automatic check_outputs();
        int p, f, c, h, v, erg;
        if (k == 0) begin
            chk("reset_rgb", {vga_r, vga_g, vga_b}, 0);
            chk("reset_hsync", vga_hsync, 1);
            chk("reset_vsync", vga_vsync, 1);
            chk("reset_frame_start", frame_start, 0);
            chk("reset_underflow", underflow, 0);
            chk("reset_sync_err", sync_err, 0);
        end else begin
            p = k - 1;
            f = p / FT;
            c = p % FT;
            h = c % HT;
            v = c / HT;
            erg = 0;
            if (h < 8 && v < 4 && show[f] >= 0 &&
                !(inj_kind == 1 && f == 1 && h == inj_x && v == inj_y))
                erg = int'(pix(show[f], h, v));
            chk("rgb", {vga_r, vga_g, vga_b}, erg);
            chk("hsync", vga_hsync, (h >= 10 && h < 12) ? 0 : 1);
            chk("vsync", vga_vsync, (v == 5) ? 0 : 1);
            chk("frame_start", frame_start, (k % FT == 0 && show[k / FT] >= 0) ? 1 : 0);
        end
    endtask

    task automatic step();
        logic fire, gap;
        @(negedge clk);
        check_outputs();
        fire = !rst && s_axis_tvalid && s_axis_tready;
        gap  = !rst && !s_axis_tvalid;
        if (fire) acc[k / FT]++;
        @(posedge clk);
        #1;
        k++;
        if (fire || gap) advance();
        drive_src();
    endtask

    task automatic run_to(input int kt);
        while (k < kt) step();
    endtask

    task automatic do_reset(input int f, input int x, input int y);
        rst = 1'b1;
        clr_status = 1'b0;
        src_f = f; src_x = x; src_y = y;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) acc[i] = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 0,  1, 2, 0, 0, 32, 32};
        vecs[1] = '{1, 3, 1, -1, 1, 1, 0, 31, 0};
        vecs[2] = '{2, 6, 0, -1, 1, 0, 1, 32, 0};
        vecs[3] = '{3, 2, 2, -1, 1, 0, 1, 32, 0};
        inj_kind = 0; inj_x = 0; inj_y = 0; k = 0;

        // Ideal stream and single-fault frames; each runs four raster frames from reset.
        for (int i = 0; i < 4; i++) begin
            inj_kind = vecs[i].kind;
            inj_x = vecs[i].ix;
            inj_y = vecs[i].iy;
            show = '{-1, 0, vecs[i].s2, vecs[i].s3, -1};
            do_reset(0, 0, 0);
            run_to(4 * FT - 1);
            chk("beats_f1", acc[1], vecs[i].exp_b1);
            chk("beats_f2", acc[2], vecs[i].exp_b2);
            chk("beats_f3", acc[3], 32);
            chk("underflow_flag", underflow, vecs[i].exp_uf);
            chk("sync_err_flag", sync_err, vecs[i].exp_se);
            if (vecs[i].exp_uf != 0 || vecs[i].exp_se != 0) begin
                clr_status = 1'b1;
                step();
                clr_status = 1'b0;
                chk("clr_underflow", underflow, 0);
                chk("clr_sync_err", sync_err, 0);
            end
        end

        // Reset released while the source is mid-frame at pixel 5 of line 2.
        inj_kind = 0;
        show = '{-1, 1, -1, -1, -1};
        do_reset(0, 5, 2);
        run_to(2 * FT - 1);
        chk("midstream_dropped", acc[0], 11);
        chk("midstream_beats_f1", acc[1], 32);
        chk("midstream_sync_err", sync_err, 0);

        // clr_status on the very cycle a stray tuser is consumed: the set wins.
        inj_kind = 3; inj_x = 2; inj_y = 2;
        show = '{-1, 0, -1, -1, -1};
        do_reset(0, 0, 0);
        run_to(FT + 2 * HT + 2);
        chk("prio_sync_err_before", sync_err, 0);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("prio_sync_err_kept", sync_err, 1);
        run_to(FT + 3 * HT);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("prio_sync_err_cleared", sync_err, 0);

        // Asynchronous reset at raster (4,3) while RUN is displaying pixels.
        inj_kind = 0;
        show = '{-1, 0, -1, -1, -1};
        do_reset(0, 0, 0);
        run_to(FT + 3 * HT + 4);
        chk("pre_rst_rgb", {vga_r, vga_g, vga_b}, int'(pix(0, 3, 3)));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("async_rst_hsync", vga_hsync, 1);
        chk("async_rst_vsync", vga_vsync, 1);
        chk("async_rst_frame_start", frame_start, 0);
        chk("async_rst_flags", {underflow, sync_err}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) acc[i] = 0;
        show = '{-1, 1, -1, -1, -1};
        run_to(2 * FT - 1);
        chk("post_rst_dropped", acc[0], 4);
        chk("post_rst_beats_f1", acc[1], 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
